// File: rtl/trap_csr_pkg.sv
// trap_csr_pkg: shared CSR addresses, mstatus bit positions, cause codes and FSM states
package trap_csr_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC = 12'h305;
    localparam logic [11:0] CSR_MEPC = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam int MIE_BIT = 3;
    localparam int MPIE_BIT = 7;
    localparam logic [7:0] CAUSE_ILLEGAL = 8'h02;
    localparam logic [7:0] CAUSE_ECALL = 8'h08;
    localparam logic [1:0] WDSEL_FROM_CSR = 2'b11;
    typedef enum logic {IDLE, SHADOW} state_t;
endpackage

// File: rtl/trap_csr_unit_csr_file.sv
// trap_csr_unit_csr_file: machine CSRs with trap/mret update, read mux and masked-OR set port
module trap_csr_unit_csr_file
    import trap_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    input  logic        set_en,
    input  logic [11:0] addr,
    input  logic [31:0] mask,
    output logic [31:0] rdata,
    output logic        mie,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);
    logic        mpie;
    logic [31:0] mcause;
    logic [31:0] mstatus;

    assign mstatus = {24'b0, mpie, 3'b0, mie, 3'b0};
    assign rdata = addr == CSR_MSTATUS ? mstatus :
                   addr == CSR_MTVEC   ? mtvec   :
                   addr == CSR_MEPC    ? mepc    :
                   addr == CSR_MCAUSE  ? mcause  : 32'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie <= 1'b0;
            mpie <= 1'b0;
            mtvec <= {MTVEC_RST[31:2], 2'b00};
            mepc <= 32'b0;
            mcause <= 32'b0;
        end else if (trap) begin
            mpie <= mie;
            mie <= 1'b0;
            mepc <= {trap_epc[31:2], 2'b00};
            mcause <= trap_cause;
        end else if (mret) begin
            mie <= mpie;
            mpie <= 1'b1;
        end else if (set_en) begin
            if (addr == CSR_MSTATUS) begin
                mie <= mie | mask[MIE_BIT];
                mpie <= mpie | mask[MPIE_BIT];
            end
            if (addr == CSR_MTVEC) mtvec <= mtvec | {mask[31:2], 2'b00};
            if (addr == CSR_MEPC) mepc <= mepc | {mask[31:2], 2'b00};
            if (addr == CSR_MCAUSE) mcause <= mcause | mask;
        end
    end
endmodule

// File: rtl/trap_csr_unit.sv
// trap_csr_unit: trap/MRET/CSRRS responder with registered redirect, flush and one-cycle shadow
module trap_csr_unit
    import trap_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
    parameter logic [31:0] MEI_CAUSE = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_int_signal,
    input  logic [7:0]  ex_scause,
    input  logic        ex_mret,
    input  logic        ex_csrrs,
    input  logic [11:0] ex_csr_addr,
    input  logic [31:0] ex_csr_mask,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        mie_o
);
    state_t      state;
    logic        accept;
    logic        take_exc;
    logic        take_irq;
    logic        do_mret;
    logic        do_set;
    logic        redirect;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    assign accept = state == IDLE && ex_valid && !stall;
    assign take_exc = accept && ex_int_signal;
    assign take_irq = accept && !ex_int_signal && ext_irq && mie_o;
    assign do_mret = accept && !ex_int_signal && !take_irq && ex_mret;
    assign do_set = accept && !ex_int_signal && !take_irq && !ex_mret && ex_csrrs && |ex_csr_mask;
    assign redirect = take_exc || take_irq || do_mret;

    trap_csr_unit_csr_file #(.MTVEC_RST(MTVEC_RST)) u_csr (
        .clk(clk),
        .rst(rst),
        .trap(take_exc || take_irq),
        .trap_epc(ex_pc),
        .trap_cause(take_exc ? {24'b0, ex_scause} : MEI_CAUSE),
        .mret(do_mret),
        .set_en(do_set),
        .addr(ex_csr_addr),
        .mask(ex_csr_mask),
        .rdata(csr_rdata),
        .mie(mie_o),
        .mtvec(mtvec),
        .mepc(mepc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            redirect_valid <= 1'b0;
            flush <= 1'b0;
            redirect_pc <= 32'b0;
        end else begin
            state <= redirect ? SHADOW : IDLE;
            redirect_valid <= redirect;
            flush <= redirect;
            if (redirect) redirect_pc <= do_mret ? mepc : mtvec;
        end
    end
endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
Trap and CSR responder for the pipelined RV32 core. It consumes the exception, MRET and CSRRS indications that the control decoder raises and carries down to EX. It holds the machine CSRs mstatus, mtvec, mepc and mcause, takes ECALL/illegal-instruction traps and gated external interrupts, and returns from traps on MRET. Toward the front end it produces a registered PC redirect plus a pipeline flush; toward the WB mux (WDSel=11) it produces CSR read data.

Parameters:
MTVEC_RST, 32'h0000_0100, reset value of mtvec (bits[1:0] must be 0)
MEI_CAUSE, 32'h8000_000B, mcause value written for the external interrupt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  pipeline stall; no CSR commit, no trap accept while 1
ex_valid  in  1  EX holds a real (non-bubble, non-flushed) instruction
ex_pc  in  32  PC of EX instruction
ex_int_signal  in  1  decoder INT_Signal (ecall/illegal), EX stage
ex_scause  in  8  decoder SCAUSE, EX stage
ex_mret  in  1  decoder MRET, EX stage
ex_csrrs  in  1  decoder CSRRS, EX stage
ex_csr_addr  in  12  instr[31:20]
ex_csr_mask  in  32  forwarded rs1 value (set mask)
ext_irq  in  1  level external interrupt request
csr_rdata  out  32  old CSR value for rd, combinational from ex_csr_addr
redirect_valid  out  1  one-cycle pulse: front end loads redirect_pc
redirect_pc  out  32  target PC
flush  out  1  kill IF/ID/EX contents; high together with redirect_valid
mie_o  out  1  mstatus.MIE, for debug

Behaviour:
- Reset (rst=1 at a clock edge):
  - mstatus.MIE=0, MPIE=0; mtvec=MTVEC_RST; mepc=0; mcause=0.
  - redirect_valid=0, redirect_pc=0, flush=0; state=IDLE.
- FSM, two states:
  - IDLE: evaluates EX inputs.
  - SHADOW: lasts exactly 1 cycle after any redirect. All EX inputs are ignored because that instruction is being flushed. Returns to IDLE unconditionally.
- Accept condition in IDLE: ex_valid & ~stall. Priority within one cycle:
  1. ex_int_signal:
     - mepc<=ex_pc, mcause<={24'b0,ex_scause}
     - MPIE<=MIE, MIE<=0
     - redirect to mtvec
  2. ext_irq & MIE (and no ex_int_signal):
     - mepc<=ex_pc (the EX instruction is not executed; it is flushed)
     - mcause<=MEI_CAUSE, MPIE<=MIE, MIE<=0
     - redirect to mtvec
  3. ex_mret:
     - MIE<=MPIE, MPIE<=1
     - redirect to mepc (the pre-update value)
  4. ex_csrrs:
     - csr_rdata is the old value.
     - If ex_csr_mask!=0: CSR<=CSR|mask, restricted to the writable bits below. Mask 0 means read only.
     - No redirect.
- Redirect timing:
  - Accept in cycle T.
  - redirect_valid=flush=1 in cycle T+1 only, with redirect_pc registered at T (mtvec or mepc as read at T).
  - State=SHADOW in T+1.
  - The earliest next accept is T+2.
- CSR map (unlisted addresses read 0, writes ignored):
  - 0x300 mstatus: only bit3 MIE and bit7 MPIE exist; other bits read 0.
  - 0x305 mtvec: bits[1:0] forced 0.
  - 0x341 mepc: bits[1:0] forced 0.
  - 0x342 mcause: full 32-bit.
- Simultaneous events:
  - A trap sets MIE=0 in the same edge, so an ext_irq pending at T+2 is masked.
  - When ext_irq and ex_mret coincide with MIE=0 (inside the handler), the MRET wins. The interrupt can be taken at T+2 once MIE has been restored.
- Stall during SHADOW: SHADOW still lasts 1 cycle. The redirect pulse is not extended; the front end must latch it.
- rst asserted in SHADOW or with a redirect pending: cleared the same edge; no redirect is emitted.
- Trap inside the handler (ecall with MIE=0): taken normally. mepc/mcause are overwritten; no nesting stack.

Decomposition:
- Shared package (or the existing ctrl_encode_def include):
  - CSR address constants CSR_MSTATUS/MTVEC/MEPC/MCAUSE
  - mstatus bit indices MIE_BIT=3, MPIE_BIT=7
  - cause codes 8'h08 (ecall) and 8'h02 (illegal)
  - WDSel_FromCSR 2'b11
  - state encodings IDLE/SHADOW
- Sub-module csr_file: CSR registers, read mux and masked-OR write port. trap_csr_unit keeps the FSM, priority and redirect logic.

Test Plan:
- Reset, then CSRRS 0x305 mask 0 -> csr_rdata=0x00000100, no redirect, mtvec unchanged.
- ecall at ex_pc=0x0000_0040, scause=0x08 -> next cycle redirect_valid=flush=1, redirect_pc=0x100; mepc=0x40, mcause=0x08, MIE=0; an ex_int_signal presented in the SHADOW cycle is ignored.
- CSRRS 0x300 mask 0x08 (MIE=1), then ext_irq=1 with ex_pc=0x80 -> redirect to 0x100, mcause=0x8000000B, mepc=0x80, MPIE=1, MIE=0; ext_irq held high -> no second trap while MIE=0.
- MRET after the previous case -> redirect_pc=0x80, MIE=1, MPIE=1; ext_irq still high -> trap accepted exactly 2 cycles after the MRET accept.
- ecall with stall=1 for 3 cycles -> no state change and no redirect; accepted on the first stall=0 cycle.
- Trap accepted, rst=1 in the following cycle -> redirect_valid=0 and all CSRs at reset values; CSRRS to 0x7C0 -> csr_rdata=0.
